// File: rtl/chart_pkg.sv
// chart_pkg: state encoding and default geometry shared by the chart
// sequencer, the hit-judge and the highway display blocks.
package chart_pkg;

    localparam int CHART_LANES       = 5;
    localparam int CHART_STEP_BITS   = 5;
    localparam int CHART_DIV_W       = 25;
    localparam int CHART_DEFAULT_DIV = 13157895;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PLAY   = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } chart_state_e;

    // A song is in progress (running or frozen) in PLAY and PAUSED.
    function automatic logic is_active(input chart_state_e s);
        return (s == PLAY) || (s == PAUSED);
    endfunction

endpackage

// File: rtl/chart_ram.sv
// chart_ram: simple-dual-port synchronous chart memory, one write port and
// one registered read port. A read of the address being written returns the
// new data, so a chart load and a playback start may share a cycle.
module chart_ram
    import chart_pkg::*;
#(
    parameter int LANES     = CHART_LANES,
    parameter int STEP_BITS = CHART_STEP_BITS
) (
    input  logic                 clk,
    input  logic                 wr_en_i,
    input  logic [STEP_BITS-1:0] wr_addr_i,
    input  logic [LANES-1:0]     wr_data_i,
    input  logic [STEP_BITS-1:0] rd_addr_i,
    output logic [LANES-1:0]     rd_data_o
);

    logic [LANES-1:0] mem_q [0:(2**STEP_BITS)-1];
    logic [LANES-1:0] rd_q;

    // Chart storage; contents survive reset so a loaded song is kept.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Registered read with write-first bypass on an address collision.
    always_ff @(posedge clk) begin
        if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
            rd_q <= wr_data_i;
        end else begin
            rd_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_q;

endmodule

// File: rtl/chart_sequencer.sv
// chart_sequencer: plays a run-time-loaded note chart at a programmable step
// rate and drives the expected-note vector to the hit-judge and highway.
// Optional build macro: CHART_LOOKAHEAD_EN adds next_notes (chart[step+1])
// through a second copy of the chart RAM.
module chart_sequencer
    import chart_pkg::*;
#(
    parameter int LANES       = CHART_LANES,
    parameter int STEP_BITS   = CHART_STEP_BITS,
    parameter int DIV_W       = CHART_DIV_W,
    parameter int DEFAULT_DIV = CHART_DEFAULT_DIV
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 pause,
    input  logic                 stop,
    input  logic                 loop_en,
    input  logic [STEP_BITS-1:0] last_step,
    input  logic [DIV_W-1:0]     period,
    input  logic                 wr_en,
    input  logic [STEP_BITS-1:0] wr_addr,
    input  logic [LANES-1:0]     wr_data,
    output logic [LANES-1:0]     exp_notes,
    output logic [STEP_BITS-1:0] step,
    output logic                 step_pulse,
    output logic                 playing,
    output logic                 song_done
`ifdef CHART_LOOKAHEAD_EN
    ,
    output logic [LANES-1:0]     next_notes
`endif
);

    localparam logic [DIV_W-1:0]     DIV_ONE        = DIV_W'(1);
    localparam logic [STEP_BITS-1:0] STEP_ONE       = STEP_BITS'(1);
    localparam logic [DIV_W-1:0]     DEFAULT_PERIOD = DIV_W'(DEFAULT_DIV);

    chart_state_e         state_q, state_d;
    logic [STEP_BITS-1:0] step_q, step_d;
    logic [STEP_BITS-1:0] last_q, last_d;
    logic [DIV_W-1:0]     cnt_q, cnt_d;
    logic [DIV_W-1:0]     period_q, period_d;
    logic [LANES-1:0]     exp_q, exp_d;
    logic                 pulse_q, pulse_d;
    logic                 playing_q, done_q;
    logic                 wr_ok_s;
    logic [LANES-1:0]     rd_notes_s;

    // The chart may only change while no song is in progress.
    assign wr_ok_s = wr_en && !is_active(state_q);

    // Main read port follows the step being entered, so its data lands one
    // cycle after the step changes.
    chart_ram #(.LANES(LANES), .STEP_BITS(STEP_BITS)) u_ram (
        .clk       (clk),
        .wr_en_i   (wr_ok_s),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_addr_i (step_d),
        .rd_data_o (rd_notes_s)
    );

    // Next state, step, divider and latches. Counting also happens in the
    // PAUSED cycle where pause drops, so a resumed step keeps its length.
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        last_d   = last_q;
        pulse_d  = 1'b0;
        if (stop) begin
            state_d = IDLE;
            step_d  = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d  = PLAY;
                        step_d   = '0;
                        cnt_d    = '0;
                        period_d = (period == '0) ? DEFAULT_PERIOD : period;
                        last_d   = last_step;
                    end else begin
                        state_d = state_q;
                    end
                end
                PLAY, PAUSED: begin
                    if (pause) begin
                        state_d = PAUSED;
                    end else if (cnt_q == (period_q - DIV_ONE)) begin
                        state_d = PLAY;
                        cnt_d   = '0;
                        if (step_q != last_q) begin
                            step_d  = step_q + STEP_ONE;
                            pulse_d = 1'b1;
                        end else if (loop_en) begin
                            step_d  = '0;
                            pulse_d = 1'b1;
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        state_d = PLAY;
                        cnt_d   = cnt_q + DIV_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    step_d  = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Expected notes: cleared outside a song, loaded from the RAM while
    // running, held while frozen.
    always_comb begin
        exp_d = exp_q;
        if (!is_active(state_d)) begin
            exp_d = '0;
        end else if (state_q == PLAY) begin
            exp_d = rd_notes_s;
        end else begin
            exp_d = exp_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            step_q    <= '0;
            last_q    <= '0;
            cnt_q     <= '0;
            period_q  <= DEFAULT_PERIOD;
            exp_q     <= '0;
            pulse_q   <= 1'b0;
            playing_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            exp_q     <= exp_d;
            pulse_q   <= pulse_d;
            playing_q <= is_active(state_d);
            done_q    <= (state_d == DONE);
        end
    end

    assign exp_notes  = exp_q;
    assign step       = step_q;
    assign step_pulse = pulse_q;
    assign playing    = playing_q;
    assign song_done  = done_q;

`ifdef CHART_LOOKAHEAD_EN
    logic [STEP_BITS-1:0] ahead_addr_s;
    logic                 ahead_live_d, ahead_live_q;
    logic [LANES-1:0]     ahead_rd_s;
    logic [LANES-1:0]     next_d, next_q;

    // Address of the step after the one being entered; past the last step
    // it wraps only in loop mode.
    always_comb begin
        if (step_d == last_d) begin
            ahead_addr_s = '0;
            ahead_live_d = loop_en;
        end else begin
            ahead_addr_s = step_d + STEP_ONE;
            ahead_live_d = 1'b1;
        end
    end

    chart_ram #(.LANES(LANES), .STEP_BITS(STEP_BITS)) u_ram_ahead (
        .clk       (clk),
        .wr_en_i   (wr_ok_s),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_addr_i (ahead_addr_s),
        .rd_data_o (ahead_rd_s)
    );

    // Look-ahead notes follow the same clear/load/hold rules as exp_notes.
    always_comb begin
        next_d = next_q;
        if (!is_active(state_d)) begin
            next_d = '0;
        end else if (state_q == PLAY) begin
            next_d = ahead_live_q ? ahead_rd_s : '0;
        end else begin
            next_d = next_q;
        end
    end

    // Look-ahead registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ahead_live_q <= 1'b0;
            next_q       <= '0;
        end else begin
            ahead_live_q <= ahead_live_d;
            next_q       <= next_d;
        end
    end

    assign next_notes = next_q;
`endif

endmodule

// File: tb/tb_chart_sequencer.sv
// Scoreboard bench for chart_sequencer: the stimulus side computes the
// expected sequence of step advances from the chart and pushes it to a
// queue; a monitor pops one entry per step_pulse / song_done rise.
module tb_chart_sequencer;

    localparam int LANES     = 5;
    localparam int STEP_BITS = 5;
    localparam int DIV_W     = 25;
    localparam int DFLT      = 6;
    localparam int PAUSE_LEN = 10;

    logic                 clk = 1'b0;
    logic                 reset, start, pause, stop, loop_en, wr_en;
    logic [STEP_BITS-1:0] last_step, wr_addr, step;
    logic [DIV_W-1:0]     period;
    logic [LANES-1:0]     wr_data, exp_notes;
    logic                 step_pulse, playing, song_done;
`ifdef CHART_LOOKAHEAD_EN
    logic [LANES-1:0]     next_notes;
`endif

    chart_sequencer #(.LANES(LANES), .STEP_BITS(STEP_BITS), .DIV_W(DIV_W),
                      .DEFAULT_DIV(DFLT)) dut (
        .clk(clk), .reset(reset), .start(start), .pause(pause), .stop(stop),
        .loop_en(loop_en), .last_step(last_step), .period(period),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .exp_notes(exp_notes), .step(step), .step_pulse(step_pulse),
        .playing(playing), .song_done(song_done)
`ifdef CHART_LOOKAHEAD_EN
        , .next_notes(next_notes)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int               step;
        logic [LANES-1:0] notes;
        logic [LANES-1:0] prev;
        int               gap;
        bit               done;
    } ev_t;

    ev_t              exp_q[$];
    logic [LANES-1:0] chart [0:31];
    int               n_checks = 0;
    int               n_err    = 0;
    int               cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, wanted %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: one scoreboard entry per advance or song end.
    initial begin : monitor
        ev_t              ev;
        bit               pend, prev_play, prev_done;
        logic [LANES-1:0] pend_notes;
        int               mark;
        pend = 0; prev_play = 0; prev_done = 0; mark = 0;
        forever begin
            @(negedge clk);
            if (pend) begin
                check("notes_after_step", exp_notes, pend_notes);
                pend = 0;
            end
            if (playing === 1'b1 && !prev_play) mark = cyc;
            if (step_pulse === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_step_pulse", 1, 0);
                end else begin
                    ev = exp_q.pop_front();
                    check("event_kind_pulse", ev.done, 0);
                    check("step_after_advance", step, ev.step);
                    check("step_period", cyc - mark, ev.gap);
                    check("notes_held_in_fetch", exp_notes, ev.prev);
                    pend = 1; pend_notes = ev.notes; mark = cyc;
                end
            end
            if (song_done === 1'b1 && !prev_done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_song_done", 1, 0);
                end else begin
                    ev = exp_q.pop_front();
                    check("event_kind_done", ev.done, 1);
                    check("done_step_held", step, ev.step);
                    check("done_period", cyc - mark, ev.gap);
                    check("done_notes_zero", exp_notes, 0);
                    check("done_not_playing", playing, 0);
                    mark = cyc;
                end
            end
            prev_play = (playing === 1'b1);
            prev_done = (song_done === 1'b1);
        end
    end

    task automatic write(input int a, input logic [LANES-1:0] d);
        wr_en = 1'b1; wr_addr = STEP_BITS'(a); wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Plays one song: builds the expected advances, starts, optionally
    // pauses in step pause_step, then stops unless the song reached DONE.
    task automatic play(input int last, input int per_in, input bit lp, input int n_adv,
                        input int pause_step, input bit wr_mid);
        int               per, s, gap, found;
        bit               paused_done, ended_done;
        logic [LANES-1:0] prev;
        ev_t              ev;
        per = (per_in == 0) ? DFLT : per_in;
        s = 0; prev = chart[0]; paused_done = 0; ended_done = 0;
        for (int a = 0; a < n_adv; a++) begin
            gap = per;
            if (!paused_done && s == pause_step) begin
                gap = gap + PAUSE_LEN;
                paused_done = 1;
            end
            if (s == last && !lp) begin
                ev.step = last; ev.notes = '0; ev.prev = prev; ev.gap = gap; ev.done = 1;
                exp_q.push_back(ev);
                ended_done = 1;
                break;
            end
            s = (s == last) ? 0 : s + 1;
            ev.step = s; ev.notes = chart[s]; ev.prev = prev; ev.gap = gap; ev.done = 0;
            exp_q.push_back(ev);
            prev = chart[s];
        end
        loop_en = lp; last_step = STEP_BITS'(last); period = DIV_W'(per_in); start = 1'b1;
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
        last_step = STEP_BITS'($urandom); period = DIV_W'($urandom);
        check("playing_after_start", playing, 1);
        check("step_after_start", step, 0);
        check("notes_before_fetch", exp_notes, 0);
        @(negedge clk);
        check("notes_step0", exp_notes, chart[0]);
        if (wr_mid) write(1, 5'b11111);
        if (pause_step >= 0) begin
            found = 0;
            for (int i = 0; i < 2000 && found == 0; i++) begin
                @(negedge clk);
                if (step_pulse === 1'b1 && step == STEP_BITS'(pause_step)) found = 1;
            end
            if (found == 0) begin
                check("timeout_pause_step", 0, 1);
            end else begin
                @(negedge clk); @(negedge clk);
                pause = 1'b1;
                for (int i = 0; i < PAUSE_LEN; i++) begin
                    @(negedge clk);
                    check("pause_step_held", step, pause_step);
                    check("pause_notes_held", exp_notes, chart[pause_step]);
                    check("pause_no_pulse", step_pulse, 0);
                end
                pause = 1'b0;
            end
        end
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            check("timeout_events", exp_q.size(), 0);
            exp_q.delete();
        end
        @(negedge clk);
        if (ended_done) begin
            check("song_done_level", song_done, 1);
        end else begin
            stop = 1'b1;
            @(negedge clk);
            stop = 1'b0;
            check("stop_not_playing", playing, 0);
            check("stop_notes_zero", exp_notes, 0);
            check("stop_not_done", song_done, 0);
        end
    endtask

    initial begin : stimulus
        int last, per, nadv, pstep;
        bit lp;
        reset = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0; loop_en = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; last_step = '0; period = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_notes", exp_notes, 0);
        check("reset_step", step, 0);
        check("reset_pulse", step_pulse, 0);
        check("reset_playing", playing, 0);
        check("reset_done", song_done, 0);

        chart[0] = 5'b00101; chart[1] = 5'b01010; chart[2] = 5'b10100; chart[3] = 5'b11000;
        for (int a = 0; a < 4; a++) write(a, chart[a]);

        play(3, 4, 1'b0, 4, -1, 1'b0);     // one-shot
        play(3, 4, 1'b1, 12, -1, 1'b0);    // three full loops
        play(3, 4, 1'b0, 4, 1, 1'b0);      // pause in step 1
        play(3, 4, 1'b0, 2, -1, 1'b0);     // stop in step 2
        play(3, 4, 1'b0, 4, -1, 1'b1);     // write dropped during play
        write(1, 5'b11111);                // accepted in DONE
        chart[1] = 5'b11111;
        play(3, 4, 1'b0, 4, -1, 1'b0);
        wr_en = 1'b1; wr_addr = '0; wr_data = 5'b10001;   // write with start
        chart[0] = 5'b10001;
        play(3, 4, 1'b0, 4, -1, 1'b0);
        play(3, 0, 1'b0, 4, -1, 1'b0);     // period 0 -> default

        for (int r = 0; r < 5; r++) begin
            last = $urandom_range(1, 7);
            for (int a = 0; a <= last; a++) begin
                chart[a] = LANES'($urandom);
                write(a, chart[a]);
            end
            per   = $urandom_range(3, 7);
            lp    = 1'($urandom_range(0, 1));
            nadv  = $urandom_range(2, 2 * (last + 1));
            pstep = ($urandom_range(0, 1) == 1) ? 1 : -1;
            play(last, per, lp, nadv, pstep, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
